// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : Instruction fetch sequencer for a synchronous instruction ROM.
//               Fetches one instruction per Step pulse, or back to back while
//               Run is high. Loads the instruction register and decodes the
//               coarse op type. Advances the PC sequentially or to a J-type
//               target, and drives a registered byte view of the IR on LED.
// Ports       : Clk, Rst (sync, active high)
//               Step (one-shot request), Run (level request), Sel (LED byte)
//               Rom_Data (in) / Rom_Addr, Rom_Rd_En (ROM interface)
//               Inst, Inst_Valid, Op_Type, PC, Busy, LED (status/datapath)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
  parameter int          ADDR_W    = 6,
  parameter int          ROM_LAT   = 1,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Step,
  input  logic              Run,
  input  logic [1:0]        Sel,
  input  logic [31:0]       Rom_Data,
  output logic [ADDR_W-1:0] Rom_Addr,
  output logic              Rom_Rd_En,
  output logic [31:0]       Inst,
  output logic              Inst_Valid,
  output logic [1:0]        Op_Type,
  output logic [31:0]       PC,
  output logic              Busy,
  output logic [7:0]        LED
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  // Byte-address width of the PC space; the PC wraps inside these bits.
  localparam int PW = ADDR_W + 2;

  // WAIT lasts ROM_LAT-1 cycles; the counter runs 0 .. ROM_LAT-2.
  localparam int               CNT_W     = (ROM_LAT > 2) ? $clog2(ROM_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((ROM_LAT > 1) ? (ROM_LAT - 2) : 0);
  localparam logic             HAS_WAIT  = (ROM_LAT > 1);

  localparam logic [1:0] OP_R    = 2'd0;
  localparam logic [1:0] OP_J    = 2'd1;
  localparam logic [1:0] OP_I    = 2'd2;
  localparam logic [1:0] OP_HALT = 2'd3;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             pend;

  // Decode of the word currently on the ROM bus (only meaningful in LATCH).
  logic             is_halt;
  logic             is_jump;
  logic [1:0]       op_dec;
  logic [31:0]      pc_seq;
  logic [31:0]      pc_jump;
  logic [PW-1:0]    pc_low_inc;

  // Next values for the registered outputs.
  logic             rd_en_nxt;
  logic             busy_nxt;
  logic [7:0]       led_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Step || Run || pend) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = HAS_WAIT ? S_WAIT : S_LATCH;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        state_nxt = is_halt ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    is_halt    = (Rom_Data == HALT_WORD);
    is_jump    = (Rom_Data[31:26] == 6'h02) || (Rom_Data[31:26] == 6'h03);

    if (is_halt) begin
      op_dec = OP_HALT;
    end else if (is_jump) begin
      op_dec = OP_J;
    end else if (Rom_Data[31:26] == 6'h00) begin
      op_dec = OP_R;
    end else begin
      op_dec = OP_I;
    end

    // Sequential advance wraps inside the ROM byte space; upper bits hold.
    pc_low_inc = PC[PW-1:0] + PW'(4);
    pc_seq     = {PC[31:PW], pc_low_inc};
    pc_jump    = {PC[31:PW], Rom_Data[ADDR_W-1:0], 2'b00};

    rd_en_nxt  = (state_nxt == S_FETCH);
    busy_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_HALT);

    case (Sel)
      2'd0:    led_nxt = Inst[7:0];
      2'd1:    led_nxt = Inst[15:8];
      2'd2:    led_nxt = Inst[23:16];
      default: led_nxt = Inst[31:24];
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Rom_Addr   <= '0;
      Rom_Rd_En  <= 1'b0;
      Inst       <= '0;
      Inst_Valid <= 1'b0;
      Op_Type    <= OP_R;
      PC         <= '0;
      Busy       <= 1'b0;
      LED        <= '0;
    end else begin
      Rom_Rd_En  <= rd_en_nxt;
      Busy       <= busy_nxt;
      Inst_Valid <= (state == S_LATCH);
      LED        <= led_nxt;
      if (rd_en_nxt) begin
        Rom_Addr <= PC[PW-1:2];
      end
      if (state == S_LATCH) begin
        Inst    <= Rom_Data;
        Op_Type <= op_dec;
        if (!is_halt) begin
          PC <= is_jump ? pc_jump : pc_seq;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // ROM latency counter and 1-deep pending Step
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wait_cnt <= '0;
      pend     <= 1'b0;
    end else begin
      if (state == S_FETCH) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      // Leaving IDLE consumes every outstanding request at once; a Step that
      // arrives while a fetch is in flight is remembered once, never queued.
      if ((state == S_IDLE) && (state_nxt == S_FETCH)) begin
        pend <= 1'b0;
      end else if (Busy && Step) begin
        pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
